// File: rtl/eth_rx_tpc_if.sv
// eth_rx_tpc_if: stream and status bundle of the RX test pattern checker.
//   Eth_Byte_Rx/Eth_Byte_Valid_Rx : received byte stream (source -> checker)
//   Cnt_Clr                       : clear of counters and first-error capture
//   Pkt_Pass/Pkt_Fail             : one-cycle per-packet verdict pulses
//   Pkt_Cnt/Err_Cnt               : saturating packet / failed-packet counters
//   Err_Seen/Err_Idx/Err_Exp/Err_Got : first-error capture for debug
// master = stream source / status consumer, slave = checker.
interface eth_rx_tpc_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       Eth_Byte_Rx;
  logic             Eth_Byte_Valid_Rx;
  logic             Cnt_Clr;
  logic             Pkt_Pass;
  logic             Pkt_Fail;
  logic [CNT_W-1:0] Pkt_Cnt;
  logic [CNT_W-1:0] Err_Cnt;
  logic             Err_Seen;
  logic [7:0]       Err_Idx;
  logic [7:0]       Err_Exp;
  logic [7:0]       Err_Got;

  modport master (
    output Eth_Byte_Rx, Eth_Byte_Valid_Rx, Cnt_Clr,
    input  Pkt_Pass, Pkt_Fail, Pkt_Cnt, Err_Cnt, Err_Seen, Err_Idx, Err_Exp, Err_Got
  );

  modport slave (
    input  Eth_Byte_Rx, Eth_Byte_Valid_Rx, Cnt_Clr,
    output Pkt_Pass, Pkt_Fail, Pkt_Cnt, Err_Cnt, Err_Seen, Err_Idx, Err_Exp, Err_Got
  );
endinterface

// File: rtl/eth_rx_tpc.sv
// eth_rx_tpc: receive-side test pattern checker. Each packet (contiguous run of
// valid-high bytes) must be exactly 1,2,...,MAX_CNT. Reports a pass/fail pulse one
// cycle after the first valid-low cycle, saturating counters and a first-error
// capture.
// Ports:
//   Clk  : system clock
//   Rst  : synchronous active-high reset
//   bus  : eth_rx_tpc_if slave (byte stream in, clear in, verdict/status out)
//
// state  | meaning
// IDLE   | waiting for the first byte of a packet
// CHECK  | inside a packet, comparing each byte with the expected pattern
// REPORT | verdict pulse cycle; a valid byte here starts the next packet
module eth_rx_tpc #(
  parameter int MAX_CNT = 100,
  parameter int CNT_W   = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  eth_rx_tpc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  localparam logic [8:0] LEN_MAX = 9'(MAX_CNT);

  state_t           state_q, state_d;
  logic [7:0]       exp_q, exp_d;
  logic [8:0]       len_q, len_d;
  logic             bad_q, bad_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q;
  logic             err_seen_q;
  logic [7:0]       err_idx_q, err_exp_q, err_got_q;

  logic             end_pkt;
  logic             cap;
  logic [7:0]       cap_idx, cap_exp, cap_got;
  logic             too_long, mism;
  logic [8:0]       len_inc;

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    len_d    = len_q;
    bad_d    = bad_q;
    pass_d   = 1'b0;
    fail_d   = 1'b0;
    end_pkt  = 1'b0;
    cap      = 1'b0;
    cap_idx  = 8'd0;
    cap_exp  = 8'd0;
    cap_got  = bus.Eth_Byte_Rx;
    too_long = (len_q >= LEN_MAX);
    mism     = (bus.Eth_Byte_Rx != exp_q);
    len_inc  = len_q + 9'd1;

    unique case (state_q)
      IDLE, REPORT: begin
        // Per-packet state restarts here; a byte in REPORT is byte 1 of the next packet.
        exp_d   = 8'd1;
        len_d   = 9'd0;
        bad_d   = 1'b0;
        state_d = IDLE;
        if (bus.Eth_Byte_Valid_Rx) begin
          exp_d   = 8'd2;
          len_d   = 9'd1;
          bad_d   = (bus.Eth_Byte_Rx != 8'd1);
          cap     = (bus.Eth_Byte_Rx != 8'd1);
          cap_idx = 8'd1;
          cap_exp = 8'd1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bus.Eth_Byte_Valid_Rx) begin
          exp_d   = exp_q + 8'd1;
          len_d   = (len_q == 9'h1FF) ? len_q : len_inc;
          cap     = too_long | mism;
          cap_idx = len_inc[7:0];
          // A too-long byte has no expected value, so it is captured as 0.
          cap_exp = too_long ? 8'd0 : exp_q;
          if (too_long || mism) bad_d = 1'b1;
        end else begin
          end_pkt = 1'b1;
          pass_d  = !bad_q && (len_q == LEN_MAX);
          fail_d  = !pass_d;
          state_d = REPORT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      exp_q      <= 8'd1;
      len_q      <= 9'd0;
      bad_q      <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_seen_q <= 1'b0;
      err_idx_q  <= 8'd0;
      err_exp_q  <= 8'd0;
      err_got_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      len_q   <= len_d;
      bad_q   <= bad_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      // Clear takes priority: an event coinciding with it is dropped.
      if (bus.Cnt_Clr) begin
        pkt_cnt_q  <= '0;
        err_cnt_q  <= '0;
        err_seen_q <= 1'b0;
        err_idx_q  <= 8'd0;
        err_exp_q  <= 8'd0;
        err_got_q  <= 8'd0;
      end else begin
        if (end_pkt && pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
        if (fail_d) begin
          err_seen_q <= 1'b1;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
        // Err_Idx of 0 means nothing captured yet since reset/clear.
        if (cap && err_idx_q == 8'd0) begin
          err_idx_q <= cap_idx;
          err_exp_q <= cap_exp;
          err_got_q <= cap_got;
        end
      end
    end
  end

  assign bus.Pkt_Pass = pass_q;
  assign bus.Pkt_Fail = fail_q;
  assign bus.Pkt_Cnt  = pkt_cnt_q;
  assign bus.Err_Cnt  = err_cnt_q;
  assign bus.Err_Seen = err_seen_q;
  assign bus.Err_Idx  = err_idx_q;
  assign bus.Err_Exp  = err_exp_q;
  assign bus.Err_Got  = err_got_q;

endmodule

// File: tb/tb_eth_rx_tpc.sv
// tb_eth_rx_tpc: directed + randomized bench for eth_rx_tpc. Two checkers share
// the same stimulus: one with 16-bit counters, one with 4-bit counters for
// saturation. Expected values come from a packet-level reference model.
module tb_eth_rx_tpc;
  localparam int MAX = 100;

  typedef logic [7:0] bq_t[$];

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  eth_rx_tpc_if #(.CNT_W(16)) bm ();
  eth_rx_tpc_if #(.CNT_W(4))  bs ();

  assign bs.Eth_Byte_Rx       = bm.Eth_Byte_Rx;
  assign bs.Eth_Byte_Valid_Rx = bm.Eth_Byte_Valid_Rx;
  assign bs.Cnt_Clr           = bm.Cnt_Clr;

  eth_rx_tpc #(.MAX_CNT(MAX), .CNT_W(16)) dut (.Clk(Clk), .Rst(Rst), .bus(bm.slave));
  eth_rx_tpc #(.MAX_CNT(MAX), .CNT_W(4))  dut_sat (.Clk(Clk), .Rst(Rst), .bus(bs.slave));

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int         m_pkt, m_err;
  bit         m_seen;
  logic [7:0] m_idx, m_exp, m_got;
  int         pass_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic bq_t good(input int n);
    bq_t q;
    for (int i = 1; i <= n; i++) q.push_back(8'(i));
    return q;
  endfunction

  // Packet verdict and first error position, straight from the pattern rules.
  function automatic void analyze(input bq_t pk, output bit pass, output int idx,
                                  output logic [7:0] e, output logic [7:0] g);
    idx = 0; e = 8'd0; g = 8'd0;
    for (int i = 1; i <= pk.size(); i++) begin
      if (i > MAX) begin
        idx = i; e = 8'd0; g = pk[i-1]; break;
      end
      if (pk[i-1] != 8'(i)) begin
        idx = i; e = 8'(i); g = pk[i-1]; break;
      end
    end
    pass = (idx == 0) && (pk.size() == MAX);
  endfunction

  task automatic model_clear();
    m_pkt = 0; m_err = 0; m_seen = 0; m_idx = 8'd0; m_exp = 8'd0; m_got = 8'd0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_pkt_cnt"},  bm.Pkt_Cnt,  sat(m_pkt, 16));
    chk({tag, "_err_cnt"},  bm.Err_Cnt,  sat(m_err, 16));
    chk({tag, "_err_seen"}, bm.Err_Seen, m_seen);
    chk({tag, "_err_idx"},  bm.Err_Idx,  m_idx);
    chk({tag, "_err_exp"},  bm.Err_Exp,  m_exp);
    chk({tag, "_err_got"},  bm.Err_Got,  m_got);
    chk({tag, "_sat_pkt"},  bs.Pkt_Cnt,  sat(m_pkt, 4));
    chk({tag, "_sat_err"},  bs.Err_Cnt,  sat(m_err, 4));
    chk({tag, "_sat_seen"}, bs.Err_Seen, m_seen);
    chk({tag, "_sat_idx"},  bs.Err_Idx,  m_idx);
  endtask

  task automatic check_pulses(input string tag, input bit p, input bit f);
    chk({tag, "_pass"},     bm.Pkt_Pass, p);
    chk({tag, "_fail"},     bm.Pkt_Fail, f);
    chk({tag, "_sat_pass"}, bs.Pkt_Pass, p);
    chk({tag, "_sat_fail"}, bs.Pkt_Fail, f);
  endtask

  // Drive a packet, end it, check the verdict cycle. Returns in the REPORT
  // cycle when gap=0 so the caller can start the next packet back-to-back.
  task automatic send(input string tag, input bq_t pk, input bit clr_t, input bit gap);
    bit pass; int idx; logic [7:0] e, g;
    analyze(pk, pass, idx, e, g);
    foreach (pk[i]) begin
      bm.Eth_Byte_Valid_Rx = 1'b1;
      bm.Eth_Byte_Rx = pk[i];
      tick();
    end
    bm.Eth_Byte_Valid_Rx = 1'b0;
    bm.Eth_Byte_Rx = 8'($urandom);
    bm.Cnt_Clr = clr_t;
    chk({tag, "_no_early_pulse"}, {bm.Pkt_Pass, bm.Pkt_Fail}, 0);
    tick();
    bm.Cnt_Clr = 1'b0;
    check_pulses(tag, pass, !pass);
    if (bm.Pkt_Pass) pass_cyc.push_back(cyc);
    m_pkt++;
    if (!pass) begin
      m_err++;
      m_seen = 1'b1;
    end
    if (m_idx == 8'd0 && idx != 0) begin
      m_idx = 8'(idx); m_exp = e; m_got = g;
    end
    if (clr_t) model_clear();
    check_status(tag);
    if (gap) begin
      tick();
      check_pulses({tag, "_after"}, 1'b0, 1'b0);
    end
  endtask

  task automatic clear_counters();
    bm.Cnt_Clr = 1'b1;
    tick();
    bm.Cnt_Clr = 1'b0;
    model_clear();
  endtask

  initial begin
    bq_t pk;
    int  len, pos, c1;

    Rst = 1'b1;
    bm.Eth_Byte_Valid_Rx = 1'b0;
    bm.Eth_Byte_Rx = 8'd0;
    bm.Cnt_Clr = 1'b0;
    model_clear();
    repeat (3) tick();
    Rst = 1'b0;
    check_pulses("reset", 1'b0, 1'b0);
    check_status("reset");

    // nominal good packet
    send("nominal", good(MAX), 1'b0, 1'b1);

    // corrupt byte 37
    pk = good(MAX);
    pk[36] = 8'h55;
    send("corrupt", pk, 1'b0, 1'b1);
    chk("corrupt_idx_lit", bm.Err_Idx, 37);
    chk("corrupt_exp_lit", bm.Err_Exp, 8'h25);
    chk("corrupt_got_lit", bm.Err_Got, 8'h55);

    // short then long
    clear_counters();
    send("short", good(MAX - 1), 1'b0, 1'b1);
    chk("short_idx_lit", bm.Err_Idx, 0);
    send("long", good(MAX + 1), 1'b0, 1'b1);
    chk("long_idx_lit", bm.Err_Idx, MAX + 1);
    chk("long_exp_lit", bm.Err_Exp, 0);
    chk("len_pkt_lit", bm.Pkt_Cnt, 2);
    chk("len_err_lit", bm.Err_Cnt, 2);

    // back-to-back with a single gap cycle
    clear_counters();
    pass_cyc.delete();
    send("b2b1", good(MAX), 1'b0, 1'b0);
    send("b2b2", good(MAX), 1'b0, 1'b1);
    chk("b2b_npass", pass_cyc.size(), 2);
    if (pass_cyc.size() == 2) chk("b2b_spacing", pass_cyc[1] - pass_cyc[0], MAX + 1);
    chk("b2b_pkt_lit", bm.Pkt_Cnt, 2);

    // reset mid-packet at byte 50, then idle
    for (int i = 1; i < 50; i++) begin
      bm.Eth_Byte_Valid_Rx = 1'b1; bm.Eth_Byte_Rx = 8'(i); tick();
    end
    bm.Eth_Byte_Rx = 8'd50;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    bm.Eth_Byte_Valid_Rx = 1'b0;
    model_clear();
    check_pulses("rst_mid", 1'b0, 1'b0);
    check_status("rst_mid");
    tick();
    check_pulses("rst_mid2", 1'b0, 1'b0);
    send("after_rst", good(MAX), 1'b0, 1'b1);

    // reset with valid held high: following bytes form a new packet
    for (int i = 1; i <= 30; i++) begin
      bm.Eth_Byte_Valid_Rx = 1'b1; bm.Eth_Byte_Rx = 8'(i); tick();
    end
    Rst = 1'b1;
    bm.Eth_Byte_Rx = 8'd31;
    tick();
    Rst = 1'b0;
    model_clear();
    send("rst_cont", good(MAX), 1'b0, 1'b1);

    // clear during a fail pulse
    send("clr_pulse", good(50), 1'b0, 1'b0);
    clear_counters();
    chk("clr_pulse_err_lit", bm.Err_Cnt, 0);
    chk("clr_pulse_seen_lit", bm.Err_Seen, 0);
    check_status("clr_pulse");

    // clear coinciding with the end-of-packet cycle: event not counted
    pk = good(MAX);
    pk[9] = 8'hAA;
    send("clr_t", pk, 1'b1, 1'b1);

    // randomized packets
    for (int n = 0; n < 24; n++) begin
      len = MAX - 2 + int'($urandom_range(0, 4));
      pk = good(len);
      if ($urandom_range(0, 2) == 0) begin
        pos = int'($urandom_range(0, len - 1));
        pk[pos] = pk[pos] + 8'(1 + $urandom_range(0, 254));
      end
      if ($urandom_range(0, 3) == 0) clear_counters();
      send("rand", pk, 1'b0, 1'($urandom_range(0, 1)));
    end

    // saturation of the 4-bit counters
    clear_counters();
    for (int n = 0; n < 17; n++) send("satpk", good(3), 1'b0, 1'($urandom_range(0, 1)));
    chk("sat_err_lit", bs.Err_Cnt, 15);
    chk("sat_pkt_lit", bs.Pkt_Cnt, 15);
    chk("wide_pkt_lit", bm.Pkt_Cnt, 17);
    send("satpk_hold", good(MAX), 1'b0, 1'b1);
    chk("sat_pkt_hold_lit", bs.Pkt_Cnt, 15);
    c1 = cyc;
    chk("cycle_budget", (c1 < 90000) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_rx_tpc.md
Name: eth_rx_tpc

Overview:
Receive-side test pattern checker, the companion of the TX test pattern generator. It monitors the RX byte stream from the ethernet receive path and checks each packet against the TX test pattern: contiguous bytes 1,2,...,MAX_CNT with valid held high. It reports a per-packet pass/fail pulse, saturating packet and error counters, and a first-error capture for debug/ILA.

Parameters:
MAX_CNT, 100, expected packet length in bytes and value of the last byte; legal range 1..255
CNT_W, 16, width of the packet and error counters

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous active-high reset
Eth_Byte_Rx  input  8  received payload byte
Eth_Byte_Valid_Rx  input  1  byte qualifier; a packet is one contiguous run of valid-high cycles
Cnt_Clr  input  1  synchronous clear of counters and first-error capture
Pkt_Pass  output  1  one-cycle pulse: packet matched the pattern exactly
Pkt_Fail  output  1  one-cycle pulse: packet had a mismatch or wrong length
Pkt_Cnt  output  CNT_W  packets ended (pass+fail), saturating
Err_Cnt  output  CNT_W  failed packets, saturating
Err_Seen  output  1  sticky, set on first failure since reset/clear
Err_Idx  output  8  byte index (1-based) of first mismatch since reset/clear
Err_Exp  output  8  expected byte at first mismatch
Err_Got  output  8  received byte at first mismatch

Behaviour:
- Clock and reset: single clock Clk. Reset Rst is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; internal expected byte = 1, length = 0, bad flag = 0.
- FSM states: IDLE, CHECK, REPORT.
- IDLE, valid=1: compare byte to 1, set expected=2, set length=1, set bad if mismatch, go to CHECK.
- IDLE, valid=0: stay in IDLE.
- CHECK, valid=1: compare byte to expected, then increment expected (8-bit, wraps 255->0) and length.
- Length is 9 bits and saturates at 511.
- A mismatch sets bad.
- A byte arriving when length is already MAX_CNT also sets bad (too long).
- CHECK, valid=0 (cycle T, end of packet): go to REPORT. The packet passes if bad=0 and length==MAX_CNT; otherwise it fails (short, long or corrupt).
- REPORT (cycle T+1):
  - Exactly one of Pkt_Pass/Pkt_Fail is high, for one cycle.
  - Pkt_Cnt increments at T+1. On fail, Err_Cnt also increments and Err_Seen is set.
  - Reset expected=1, length=0, bad=0.
  - If valid=1 during REPORT, treat it as the first byte of a new packet (same as IDLE with valid=1) and go to CHECK. Otherwise go to IDLE.
  - So back-to-back packets separated by a one-cycle gap are supported.
- First-error capture:
  - On the first mismatching byte since reset/clear (Err_Idx==0), load Err_Idx=byte index, Err_Exp, and Err_Got.
  - For a too-long error, Err_Exp=0.
  - Later errors do not overwrite the capture.
  - A short packet (length<MAX_CNT) with no mismatch fails, but Err_Idx stays unchanged.
- Counters saturate at all-ones and do not wrap.
- Cnt_Clr:
  - Zeroes Pkt_Cnt, Err_Cnt, Err_Seen, Err_Idx, Err_Exp and Err_Got.
  - Clear wins over a simultaneous increment or capture; the event is not counted.
  - Does not affect the FSM or the Pkt_Pass/Pkt_Fail pulses.
- Reset mid-packet: return to IDLE immediately. No pass/fail pulse for the aborted packet, counters zeroed. Bytes after reset while valid stays high are checked as a new packet starting at expected=1.
- Latency: end-of-packet detection (first valid-low cycle, T) to pulse is 1 cycle.
- No backpressure: the checker is always ready.

Test Plan:
- Nominal: drive one packet of bytes 1..100 with contiguous valid, then valid low at T. Require Pkt_Pass=1 at T+1 only, Pkt_Cnt=1, Err_Cnt=0, Err_Seen=0.
- Corrupt byte: same packet with byte 37 replaced by 0x55. Require Pkt_Fail pulse, Err_Cnt=1, Err_Idx=37, Err_Exp=0x25, Err_Got=0x55.
- Length errors:
  - Packet 1..99: require Pkt_Fail and Err_Idx=0.
  - Packet 1..101: require Pkt_Fail, Err_Idx=101, Err_Exp=0.
  - After both, Pkt_Cnt=2, Err_Cnt=2.
- Back-to-back: two good packets separated by exactly one valid-low cycle. Require two Pkt_Pass pulses 101 cycles apart and Pkt_Cnt=2; the first byte of packet 2 lands in the REPORT cycle.
- Reset/clear:
  - Assert Rst at byte 50 for one cycle: require no pulse, all outputs 0.
  - Then drive a good packet: require Pkt_Pass.
  - Assert Cnt_Clr in the same cycle as a Pkt_Fail pulse: require Err_Cnt=0 and Err_Seen=0 on the next cycle.
- Saturation (CNT_W=4): send 17 bad packets. Require Err_Cnt=15 and Pkt_Cnt=15, held at 15 with no wrap.
